// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - register map constants and cause encoder for irq_ctrl
package irq_ctrl_pkg;

  localparam logic [2:0] OFF_PENDING   = 3'd0;
  localparam logic [2:0] OFF_ENABLE    = 3'd1;
  localparam logic [2:0] OFF_CLEAR     = 3'd2;
  localparam logic [2:0] OFF_EDGE_MODE = 3'd3;
  localparam logic [2:0] OFF_CAUSE     = 3'd4;
  localparam logic [2:0] OFF_MASTER    = 3'd5;

  localparam int CAUSE_VALID_BIT = 7;
  localparam int MASTER_BIT      = 0;

  // Lowest set index wins; {valid, 4'b0, idx} with all zeros when nothing is set.
  function automatic logic [7:0] cause_encode(input logic [7:0] req);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        c                  = 8'h00;
        c[CAUSE_VALID_BIT] = 1'b1;
        c[2:0]             = 3'(i);
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// rtl/irq_ctrl_sync.sv - per-line 2-flop synchronizer with rising-edge detect
module irq_sync (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Two metastability flops, then one delay flop so the edge is seen on synchronized data.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - memory-mapped interrupt controller on the CPU byte bus
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          NUM_IRQ   = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  inout  logic [7:0]           data,
  input  logic                 cs_,
  input  logic                 oe_,
  input  logic                 we_,
  input  logic [NUM_IRQ-1:0]   irq_in,
  output logic                 cpu_int,
  input  logic                 cpu_int_ack
);

  // Bits at or above NUM_IRQ never hold state.
  localparam logic [7:0] IRQ_MASK = 8'((16'd1 << NUM_IRQ) - 16'd1);

  logic       sel;
  logic [2:0] offset;
  logic       rd_term;
  logic       wr_term;
  logic       wr_prev;
  logic       commit;
  logic [7:0] wdata;
  logic [7:0] rd_mux;
  logic [7:0] data_out;
  logic [7:0] clr_mask;

  logic [7:0] pending;
  logic [7:0] enable;
  logic [7:0] edge_mode;
  logic [7:0] cause;
  logic       master;
  logic       ack_prev;
  logic       ack_rise;

  logic [7:0] irq_level;
  logic [7:0] irq_rise;

  assign sel     = (addr[31:3] == BASE_ADDR[31:3]);
  assign offset  = addr[2:0];
  assign rd_term = sel & ~cs_ & ~oe_ & we_;
  assign wr_term = sel & ~cs_ & ~we_;
  assign commit  = wr_term & ~wr_prev;
  assign wdata   = data & IRQ_MASK;
  assign clr_mask = (commit && offset == OFF_CLEAR) ? wdata : 8'h00;
  assign ack_rise = cpu_int_ack & ~ack_prev;

  assign data = rd_term ? data_out : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_line
    if (i < NUM_IRQ) begin : g_used
      irq_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .irq_in (irq_in[i]),
        .level  (irq_level[i]),
        .rise   (irq_rise[i])
      );
    end else begin : g_unused
      assign irq_level[i] = 1'b0;
      assign irq_rise[i]  = 1'b0;
    end
  end

  // Register read multiplexer; CLEAR and the unused offsets read as zero.
  always_comb begin
    rd_mux = 8'h00;
    case (offset)
      OFF_PENDING:   rd_mux = pending;
      OFF_ENABLE:    rd_mux = enable;
      OFF_EDGE_MODE: rd_mux = edge_mode;
      OFF_CAUSE:     rd_mux = cause;
      OFF_MASTER:    rd_mux[MASTER_BIT] = master;
      default:       rd_mux = 8'h00;
    endcase
  end

  // Bus bookkeeping; wr_prev tracks the strobe even in reset so a cycle cut by reset never commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 8'h00;
      wr_prev  <= wr_term;
      ack_prev <= 1'b0;
    end else begin
      if (rd_term) begin
        data_out <= rd_mux;
      end
      wr_prev  <= wr_term;
      ack_prev <= cpu_int_ack;
    end
  end

  // ENABLE and EDGE_MODE take the bus value once per write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable    <= 8'h00;
      edge_mode <= 8'h00;
    end else if (commit) begin
      case (offset)
        OFF_ENABLE:    enable    <= wdata;
        OFF_EDGE_MODE: edge_mode <= wdata;
        default:       ;
      endcase
    end
  end

  // MASTER: an acknowledge edge overrides a simultaneous software write.
  always_ff @(posedge clk) begin
    if (rst) begin
      master <= 1'b0;
    end else if (ack_rise) begin
      master <= 1'b0;
    end else if (commit && offset == OFF_MASTER) begin
      master <= wdata[MASTER_BIT];
    end
  end

  // PENDING: edge lines latch and clear (new edge beats clear), level lines follow the input.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 8'h00;
    end else begin
      pending <= ((edge_mode & ((pending & ~clr_mask) | irq_rise)) |
                  (~edge_mode & irq_level)) & IRQ_MASK;
    end
  end

  // CAUSE and cpu_int are registered from the enabled pending set.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause   <= 8'h00;
      cpu_int <= 1'b0;
    end else begin
      cause   <= cause_encode(pending & enable);
      cpu_int <= master & (|(pending & enable));
    end
  end

endmodule
